// File: rtl/uart_protocol_tx.sv
// Frame serialiser for the image/label UART link: FF, mode, pixels, label, checksum, 0F.
// Define RESEND_EN to add the S_WAIT checksum-verdict state with a single retransmission.
module uart_protocol_tx #(
  parameter int IMG_SZ = 784 << 3
) (
  input  logic              uart_sampling_clk,
  input  logic              rst,
  input  logic              send,
  input  logic              train,
  input  logic [IMG_SZ-1:0] image,
  input  logic [7:0]        label,
  input  logic              tx_ready,
  input  logic              resend,
  input  logic              ack,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       byte_count
);

  localparam logic [15:0] NBYTES = 16'(IMG_SZ / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_MODE,
    S_DATA,
    S_LABEL,
    S_CHECK,
`ifdef RESEND_EN
    S_WAIT,
`endif
    S_STOP
  } state_t;

  state_t              r_state;
  logic [IMG_SZ-1:0]   r_img;
  logic [7:0]          r_label;
  logic [7:0]          r_mode;
  logic [7:0]          r_checksum;
  logic [7:0]          w_next_byte;
  logic                w_xfer;
`ifdef RESEND_EN
  logic [IMG_SZ-1:0]   r_img_copy;
  logic                r_resent;
`else
  logic                w_unused;
  assign w_unused = resend | ack;
`endif

  // One's-complement add: the carry out of bit 7 wraps back into bit 0.
  function automatic logic [7:0] ones_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

  assign w_xfer = tx_valid && tx_ready;

  always_comb begin
    w_next_byte = 8'h00;
    case (r_state)
      S_START: w_next_byte = 8'hFF;
      S_MODE:  w_next_byte = r_mode;
      S_DATA:  w_next_byte = r_img[7:0];
      S_LABEL: w_next_byte = r_label;
      S_CHECK: w_next_byte = r_checksum;
      S_STOP:  w_next_byte = 8'h0F;
      default: w_next_byte = 8'h00;
    endcase
  end

  // A transfer drops tx_valid for one cycle; the following cycle presents the next byte.
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_img      <= '0;
      r_label    <= 8'h00;
      r_mode     <= 8'h00;
      r_checksum <= 8'h00;
      tx_byte    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_count <= 16'd0;
`ifdef RESEND_EN
      r_img_copy <= '0;
      r_resent   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (send) begin
          r_img      <= image;
          r_label    <= label;
          r_mode     <= train ? 8'hF0 : 8'h0F;
          r_checksum <= 8'h00;
          byte_count <= 16'd0;
          busy       <= 1'b1;
          tx_byte    <= 8'hFF;
          tx_valid   <= 1'b1;
          r_state    <= S_START;
`ifdef RESEND_EN
          r_img_copy <= image;
`endif
        end
      end else if (w_xfer) begin
        tx_valid <= 1'b0;
        case (r_state)
          S_START: r_state <= S_MODE;
          S_MODE:  r_state <= S_DATA;
          S_DATA: begin
            r_img      <= r_img >> 8;
            byte_count <= byte_count + 16'd1;
            r_checksum <= ones_add(r_checksum, r_img[7:0]);
            if (byte_count == NBYTES - 16'd1) r_state <= S_LABEL;
          end
          S_LABEL: begin
            r_checksum <= ones_add(r_checksum, r_label);
            r_state    <= S_CHECK;
          end
`ifdef RESEND_EN
          S_CHECK: r_state <= S_WAIT;
`else
          S_CHECK: r_state <= S_STOP;
`endif
          S_STOP: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
`ifdef RESEND_EN
            r_resent <= 1'b0;
`endif
          end
          default: r_state <= r_state;
        endcase
      end else if (!tx_valid) begin
`ifdef RESEND_EN
        if (r_state == S_WAIT) begin
          // A second resend in the same frame is taken as an ack.
          if (resend && !r_resent) begin
            r_resent   <= 1'b1;
            r_img      <= r_img_copy;
            r_checksum <= 8'h00;
            byte_count <= 16'd0;
            r_state    <= S_START;
          end else if (resend || ack) begin
            r_state <= S_STOP;
          end
        end else begin
          tx_byte  <= w_next_byte;
          tx_valid <= 1'b1;
        end
`else
        tx_byte  <= w_next_byte;
        tx_valid <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_protocol_tx.sv
// Directed bench for uart_protocol_tx with IMG_SZ=32; hand-computed byte streams.
module tb_uart_protocol_tx;

  localparam int IMG_SZ = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              send = 1'b0;
  logic              train = 1'b0;
  logic [IMG_SZ-1:0] image = '0;
  logic [7:0]        label = 8'h00;
  logic              tx_ready = 1'b0;
  logic              resend = 1'b0;
  logic              ack = 1'b0;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              busy;
  logic              done;
  logic [15:0]       byte_count;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_done = 0;
  int         stall_bad = 0;
  logic       stall = 1'b0;
  logic [7:0] stall_byte = 8'h00;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];

  uart_protocol_tx #(.IMG_SZ(IMG_SZ)) dut (
    .uart_sampling_clk(clk),
    .rst(rst),
    .send(send),
    .train(train),
    .image(image),
    .label(label),
    .tx_ready(tx_ready),
    .resend(resend),
    .ack(ack),
    .tx_byte(tx_byte),
    .tx_valid(tx_valid),
    .busy(busy),
    .done(done),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Byte monitor: records transfers, counts done pulses, flags a stalled byte that changes.
  always @(negedge clk) begin
    if (rst) begin
      stall <= 1'b0;
    end else begin
      if (stall && !(tx_valid && tx_byte == stall_byte)) stall_bad <= stall_bad + 1;
      if (tx_valid && tx_ready) q.push_back(tx_byte);
      if (done) n_done <= n_done + 1;
      stall      <= tx_valid && !tx_ready;
      stall_byte <= tx_byte;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_stream(input string tag, input int qb);
    chk({tag, "_len"}, 32'(q.size() - qb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (qb + i < q.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(q[qb + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] img, input logic [7:0] lbl,
                           input logic trn, input bit rnd, input bit dup_send, input bit use_resend);
    int qb;
    int db;
    int sb;
`ifdef RESEND_EN
    int last_sz;
    last_sz = -1;
`endif
    qb = q.size();
    db = n_done;
    sb = stall_bad;
    @(posedge clk); #1;
    image = img; label = lbl; train = trn; send = 1'b1;
    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_after_send"}, 32'(tx_valid), 32'd1);
    chk({tag, "_busy_after_send"}, 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 300 && n_done == db; cyc++) begin
      @(posedge clk); #1;
      send = 1'b0; resend = 1'b0; ack = 1'b0;
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      if (dup_send && cyc == 6) begin
        send = 1'b1; image = 32'hDEADBEEF; label = 8'h55; train = ~trn;
      end
`ifdef RESEND_EN
      if (q.size() > qb && ((q.size() - qb) % 8 == 0) && !tx_valid && busy && q.size() != last_sz) begin
        last_sz = q.size();
        if (use_resend) resend = 1'b1;
        else ack = 1'b1;
      end
`else
      if (use_resend) ack = 1'b0;
`endif
    end
    @(posedge clk); #1;
    send = 1'b0; resend = 1'b0; ack = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(n_done - db), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_valid_end"}, 32'(tx_valid), 32'd0);
    chk({tag, "_byte_count"}, 32'(byte_count), 32'd4);
    chk({tag, "_stall_hold"}, 32'(stall_bad - sb), 32'd0);
    check_stream(tag, qb);
  endtask

  initial begin
    int qb;
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    exp_q = '{8'hFF, 8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h11, 8'h0F};
    run_frame("train", 32'h04030201, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);

    exp_q = '{8'hFF, 8'h0F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h11, 8'h0F};
    run_frame("test", 32'h04030201, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);

    exp_q = '{8'hFF, 8'hF0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h0F};
    run_frame("carry", 32'h000000FF, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

    exp_q = '{8'hFF, 8'h0F, 8'h01, 8'h80, 8'hC3, 8'hA5, 8'h3C, 8'h27, 8'h0F};
    run_frame("stall", 32'hA5C38001, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset after the third pixel byte.
    qb = q.size();
    @(posedge clk); #1;
    image = 32'h04030201; label = 8'h07; train = 1'b1; send = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    for (int cyc = 0; cyc < 50 && (q.size() - qb) < 5; cyc++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_byte_count", 32'(byte_count), 32'd0);
    chk("midrst_sent", 32'(q.size() - qb), 32'd5);
    if (q.size() - qb >= 5) chk("midrst_last", 32'(q[qb + 4]), 32'h03);
    @(posedge clk); #1;
    rst = 1'b0;

    exp_q = '{8'hFF, 8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h11, 8'h0F};
    run_frame("after_rst", 32'h04030201, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef RESEND_EN
    exp_q = '{8'hFF, 8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h11,
              8'hFF, 8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07, 8'h11, 8'h0F};
    run_frame("resend", 32'h04030201, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
